// File: rtl/sog_aead_core.sv
// Iterative 128-bit keyed-permutation AEAD core (encrypt / decrypt+verify).
// Optional SOG_DOUBLE_ROUND_EN: two chained rounds per cycle, same results.
module sog_aead_core #(
  parameter int NROUNDS = 12,
  parameter int TAG_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               eoc,
  input  logic [447:0]       K,
  input  logic [127:0]       S,
  input  logic [127:0]       NONCE,
  input  logic [127:0]       A,
  input  logic [127:0]       P,
  input  logic [TAG_W-1:0]   TAGIN,
  output logic [127:0]       C,
  output logic [TAG_W-1:0]   TAG,
  output logic               done,
  output logic               FAILURE
);

  localparam int RW = $clog2(3*NROUNDS + 1);
`ifdef SOG_DOUBLE_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  typedef enum logic [2:0] {IDLE, INIT, ABS_A, ABS_C, DONE} state_t;

  state_t             state, next_state;
  logic [127:0]       x, z;
  logic [RW-1:0]      r, r_nxt, phase_end;
  logic               last;
  logic [447:0]       k_reg;
  logic [127:0]       a_reg, p_reg, ct;
  logic [TAG_W-1:0]   tagin_reg;
  logic               eoc_reg;

  function automatic logic [127:0] round_fn(input logic [127:0] xi,
                                            input logic [RW-1:0]  rc,
                                            input logic [447:0]   k);
    logic [31:0] x0, x1, x2, x3;
    logic [8:0]  base;
    {x3, x2, x1, x0} = xi;
    x0 = x0 + x1;
    x3 = x3 ^ x0;
    x3 = {x3[15:0], x3[31:16]};
    x2 = x2 + x3;
    x1 = x1 ^ x2;
    x1 = {x1[19:0], x1[31:20]};
    base = 9'((32'(rc) % 32'd14) * 32'd32);
    x0 = x0 ^ k[base +: 32];
    x2 = x2 ^ 32'(rc);
    return {x3, x2, x1, x0};
  endfunction

`ifdef SOG_DOUBLE_ROUND_EN
  assign z = round_fn(round_fn(x, r, k_reg), r + RW'(1), k_reg);
`else
  assign z = round_fn(x, r, k_reg);
`endif

  assign r_nxt = r + RW'(STEP);
  // Absorbed value is Z ^ ciphertext, which is the plaintext in either mode.
  assign ct = eoc_reg ? p_reg : (p_reg ^ z);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    phase_end  = '0;
    last       = 1'b0;
    case (state)
      INIT:  phase_end = RW'(NROUNDS);
      ABS_A: phase_end = RW'(2*NROUNDS);
      ABS_C: phase_end = RW'(3*NROUNDS);
      default: phase_end = '0;
    endcase
    if (state == INIT || state == ABS_A || state == ABS_C)
      last = (r_nxt == phase_end);
    case (state)
      IDLE:  if (en)   next_state = INIT;
      INIT:  if (last) next_state = ABS_A;
      ABS_A: if (last) next_state = ABS_C;
      ABS_C: if (last) next_state = DONE;
      DONE:  if (!en)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x         <= '0;
      r         <= '0;
      C         <= '0;
      TAG       <= '0;
      done      <= 1'b0;
      FAILURE   <= 1'b0;
      k_reg     <= '0;
      a_reg     <= '0;
      p_reg     <= '0;
      tagin_reg <= '0;
      eoc_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          k_reg     <= K;
          a_reg     <= A;
          p_reg     <= P;
          tagin_reg <= TAGIN;
          eoc_reg   <= eoc;
          x         <= S ^ NONCE;
          r         <= '0;
        end
        INIT: begin
          r <= r_nxt;
          x <= last ? (z ^ a_reg) : z;
        end
        ABS_A: begin
          r <= r_nxt;
          if (last) begin
            C <= p_reg ^ z;
            x <= z ^ ct;
          end else begin
            x <= z;
          end
        end
        ABS_C: begin
          r <= r_nxt;
          x <= z;
          if (last) begin
            TAG     <= z[TAG_W-1:0];
            FAILURE <= eoc_reg && (z[TAG_W-1:0] != tagin_reg);
            done    <= 1'b1;
          end
        end
        DONE: if (!en) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sog_aead_core.sv
// Scoreboard bench for sog_aead_core: randomized and directed runs against a
// round-by-round reference model; a negedge monitor checks each done rise.
module tb_sog_aead_core;

  localparam int NR = 12;
  localparam int TW = 1;
`ifdef SOG_DOUBLE_ROUND_EN
  localparam int LAT = 3*NR/2 + 1;
`else
  localparam int LAT = 3*NR + 1;
`endif

  logic           clk = 1'b0;
  logic           rst, en, eoc;
  logic [447:0]   K;
  logic [127:0]   S, NONCE, A, P;
  logic [TW-1:0]  TAGIN;
  logic [127:0]   C;
  logic [TW-1:0]  TAG;
  logic           done, FAILURE;

  sog_aead_core #(.NROUNDS(NR), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .en(en), .eoc(eoc), .K(K), .S(S), .NONCE(NONCE),
    .A(A), .P(P), .TAGIN(TAGIN), .C(C), .TAG(TAG), .done(done),
    .FAILURE(FAILURE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]  c;
    logic [TW-1:0] tag;
    logic          fail;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  logic [127:0]  exp_c;
  logic [TW-1:0] exp_tag;
  logic          exp_fail;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Reference: apply the 3*NR rounds with the phase actions at r=NR-1 and 2NR-1.
  function automatic void model(input logic [447:0] k, input logic [127:0] s,
                                input logic [127:0] n, input logic [127:0] a,
                                input logic [127:0] p, input logic e,
                                input logic [TW-1:0] ti,
                                output logic [127:0] c, output logic [TW-1:0] tag,
                                output logic f);
    logic [31:0]  w[4];
    logic [127:0] st, zz;
    st = s ^ n;
    c  = '0;
    for (int r = 0; r < 3*NR; r++) begin
      for (int i = 0; i < 4; i++) w[i] = st[32*i +: 32];
      w[0] = w[0] + w[1];
      w[3] = w[3] ^ w[0];
      w[3] = (w[3] << 16) | (w[3] >> 16);
      w[2] = w[2] + w[3];
      w[1] = w[1] ^ w[2];
      w[1] = (w[1] << 12) | (w[1] >> 20);
      w[0] = w[0] ^ k[32*(r % 14) +: 32];
      w[2] = w[2] ^ 32'(r);
      st = {w[3], w[2], w[1], w[0]};
      if (r == NR-1) st = st ^ a;
      else if (r == 2*NR-1) begin
        zz = st;
        c  = p ^ zz;
        st = e ? (zz ^ p) : p;
      end
    end
    tag = st[TW-1:0];
    f   = e && (tag != ti);
  endfunction

  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done got=1 want=0");
      end else begin
        mon_e = q.pop_front();
        chk("sb_c", C, mon_e.c);
        chk("sb_tag", 128'(TAG), 128'(mon_e.tag));
        chk("sb_failure", 128'(FAILURE), 128'(mon_e.fail));
      end
    end
    prev_done = done;
  end

  task automatic start(input logic [447:0] k, input logic [127:0] s, input logic [127:0] n,
                       input logic [127:0] a, input logic [127:0] p, input logic e,
                       input logic [TW-1:0] ti, input bit push);
    exp_t ex;
    @(negedge clk);
    K = k; S = s; NONCE = n; A = a; P = p; eoc = e; TAGIN = ti;
    model(k, s, n, a, p, e, ti, exp_c, exp_tag, exp_fail);
    ex.c = exp_c; ex.tag = exp_tag; ex.fail = exp_fail;
    if (push) q.push_back(ex);
    en = 1'b1;
  endtask

  // Edge count includes the edge that samples en=1; optionally corrupt P mid-run.
  task automatic run_wait(input string name, input int mutate_at);
    int n = 1;
    @(posedge clk); #1;
    while (!done && n < 200) begin
      if (n == mutate_at) P = ~P;
      @(posedge clk); #1;
      n++;
    end
    chk(name, 128'(n), 128'(LAT));
  endtask

  task automatic end_run(input string name);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk(name, 128'(done), 128'(0));
  endtask

  localparam logic [447:0] K1 = 448'h62427358796268566450626339617544;
  localparam logic [127:0] S1 = 128'h646f416454534a3932677445756b734c;
  localparam logic [127:0] A1 = 128'h7a5844494c483139656e4265626b5776;
  localparam logic [127:0] N1 = 128'h744d64476b41465555757a666d694f38;
  localparam logic [127:0] P1 = 128'h363174644f47387a39616d6c796c6759;

  logic [127:0]  c_enc, zc;
  logic [TW-1:0] tag_enc;
  logic [447:0]  rk;

  initial begin
    rst = 1'b0; en = 1'b0; eoc = 1'b0; K = '0; S = '0; NONCE = '0; A = '0; P = '0;
    TAGIN = '0;
    #12;
    chk("rst_c", C, 0);
    chk("rst_tag", 128'(TAG), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_failure", 128'(FAILURE), 0);
    @(negedge clk) rst = 1'b1;

    // Encrypt, hold, release
    start(K1, S1, N1, A1, P1, 1'b0, '0, 1);
    run_wait("enc_latency", -1);
    chk("enc_c_ne_p", 128'(C !== P1), 1);
    c_enc = exp_c; tag_enc = exp_tag;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_done", 128'(done), 1);
      chk("hold_c", C, c_enc);
      chk("hold_tag", 128'(TAG), 128'(tag_enc));
    end
    end_run("drop_done");
    chk("drop_c_kept", C, c_enc);

    // Round trip
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    start(K1, S1, N1, A1, c_enc, 1'b1, tag_enc, 1);
    run_wait("dec_latency", -1);
    chk("dec_plain", C, P1);
    chk("dec_tag", 128'(TAG), 128'(tag_enc));
    chk("dec_failure", 128'(FAILURE), 0);
    end_run("dec_drop");

    // Tamper: inverted tag, then flipped ciphertext bit
    start(K1, S1, N1, A1, c_enc, 1'b1, ~tag_enc, 1);
    run_wait("tamper_tag_latency", -1);
    chk("tamper_tag_failure", 128'(FAILURE), 1);
    end_run("tamper_tag_drop");
    start(K1, S1, N1, A1, c_enc ^ 128'd1, 1'b1, tag_enc, 1);
    run_wait("tamper_bit_latency", -1);
    chk("tamper_bit_diff", C ^ P1, 1);
    end_run("tamper_bit_drop");

    // Reset mid-run, then a fresh identical run
    start(K1, S1, N1, A1, P1, 1'b0, '0, 0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0; en = 1'b0;
    #1;
    chk("abort_c", C, 0);
    chk("abort_tag", 128'(TAG), 0);
    chk("abort_done", 128'(done), 0);
    chk("abort_failure", 128'(FAILURE), 0);
    @(negedge clk) rst = 1'b1;
    start(K1, S1, N1, A1, P1, 1'b0, '0, 1);
    run_wait("fresh_latency", -1);
    chk("fresh_c", C, c_enc);
    end_run("fresh_drop");

    // P changed mid-run is ignored (expected uses the original P)
    start(K1, S1, N1, A1, P1, 1'b0, '0, 1);
    run_wait("mutate_latency", 5);
    chk("mutate_c", C, c_enc);
    end_run("mutate_drop");

    // All-zero inputs twice: C is the raw keystream
    start('0, '0, '0, '0, '0, 1'b0, '0, 1);
    run_wait("zero1_latency", -1);
    zc = exp_c;
    end_run("zero1_drop");
    start('0, '0, '0, '0, '0, 1'b0, '0, 1);
    run_wait("zero2_latency", -1);
    chk("zero_repeat", C, zc);
    end_run("zero2_drop");

    // Random runs in both modes
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 14; j++) rk[32*j +: 32] = $urandom;
      start(rk, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), TW'($urandom), 1);
      run_wait("rand_latency", -1);
      end_run("rand_drop");
    end

    @(negedge clk);
    chk("sb_drained", 128'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
